// File: rtl/elixirchip_es1_spu_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier between NUM_PORTS requesters.
// Requester IDs travel through a tag pipeline matched to MUL_LATENCY so each result returns to its origin.
module elixirchip_es1_spu_mul_arbiter #(
    parameter  int NUM_PORTS   = 4,
    parameter  int DATA0_BITS  = 8,
    parameter  int DATA1_BITS  = 8,
    parameter  int RESULT_BITS = 16,
    parameter  int MUL_LATENCY = 3,
    parameter  int BURST       = 1,
    localparam int ID_BITS     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            cke,
    input  logic [NUM_PORTS*DATA0_BITS-1:0] s_data0,
    input  logic [NUM_PORTS*DATA1_BITS-1:0] s_data1,
    input  logic [NUM_PORTS-1:0]            s_valid,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic [DATA0_BITS-1:0]           m_mul_data0,
    output logic [DATA1_BITS-1:0]           m_mul_data1,
    output logic                            m_mul_valid,
    input  logic [RESULT_BITS-1:0]          s_mul_data,
    output logic [RESULT_BITS-1:0]          m_data,
    output logic [ID_BITS-1:0]              m_id,
    output logic [NUM_PORTS-1:0]            m_valid
);

    localparam int unsigned          NP       = NUM_PORTS;
    localparam int                   CNT_BITS = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = CNT_BITS'(BURST - 1);
    localparam logic [ID_BITS-1:0]   PTR_INIT = ID_BITS'(NUM_PORTS - 1);

    logic [DATA0_BITS-1:0]  w_op0 [NUM_PORTS];
    logic [DATA1_BITS-1:0]  w_op1 [NUM_PORTS];

    logic [ID_BITS-1:0]     r_ptr;
    logic                   r_have_last;
    logic [CNT_BITS-1:0]    r_burst_cnt;

    logic                   w_hold;
    logic                   w_grant_valid;
    logic [ID_BITS-1:0]     w_grant_id;
    logic [ID_BITS-1:0]     w_cand;

    logic                   r_mul_valid;
    logic [ID_BITS-1:0]     r_mul_id;
    logic [DATA0_BITS-1:0]  r_mul_data0;
    logic [DATA1_BITS-1:0]  r_mul_data1;

    logic                   r_tag_valid [MUL_LATENCY];
    logic [ID_BITS-1:0]     r_tag_id    [MUL_LATENCY];

    logic [NUM_PORTS-1:0]   w_res_onehot;
    logic [RESULT_BITS-1:0] r_m_data;
    logic [ID_BITS-1:0]     r_m_id;
    logic [NUM_PORTS-1:0]   r_m_valid;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign w_op0[gi] = s_data0[gi*DATA0_BITS +: DATA0_BITS];
        assign w_op1[gi] = s_data1[gi*DATA1_BITS +: DATA1_BITS];
    end

    // The previous winner keeps the grant while its burst allowance lasts; otherwise
    // search starts one past the pointer so the last winner is considered last.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        w_cand        = '0;
        w_hold        = r_have_last && s_valid[r_ptr] && (r_burst_cnt < CNT_MAX);
        if (cke && reset_n) begin
            if (w_hold) begin
                w_grant_valid = 1'b1;
                w_grant_id    = r_ptr;
            end else begin
                for (int unsigned off = 1; off <= NP; off++) begin
                    w_cand = ID_BITS'((32'(r_ptr) + off) % NP);
                    if (!w_grant_valid && s_valid[w_cand]) begin
                        w_grant_valid = 1'b1;
                        w_grant_id    = w_cand;
                    end
                end
            end
        end
    end

    always_comb begin
        s_ready = '0;
        if (w_grant_valid) begin
            s_ready[w_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= PTR_INIT;
            r_have_last <= 1'b0;
            r_burst_cnt <= '0;
            r_mul_valid <= 1'b0;
            r_mul_id    <= '0;
            r_mul_data0 <= '0;
            r_mul_data1 <= '0;
        end else if (cke) begin
            r_mul_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_mul_id    <= w_grant_id;
                r_mul_data0 <= w_op0[w_grant_id];
                r_mul_data1 <= w_op1[w_grant_id];
                r_ptr       <= w_grant_id;
                r_have_last <= 1'b1;
                // Saturating: beyond BURST-1 only the round-robin search applies.
                if (r_have_last && (w_grant_id == r_ptr)) begin
                    if (r_burst_cnt != CNT_MAX) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end else begin
                    r_burst_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                r_tag_valid[i] <= 1'b0;
                r_tag_id[i]    <= '0;
            end
        end else if (cke) begin
            r_tag_valid[0] <= r_mul_valid;
            r_tag_id[0]    <= r_mul_id;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_id[i]    <= r_tag_id[i-1];
            end
        end
    end

    always_comb begin
        w_res_onehot = '0;
        w_res_onehot[r_tag_id[MUL_LATENCY-1]] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m_data  <= '0;
            r_m_id    <= '0;
            r_m_valid <= '0;
        end else if (cke) begin
            if (r_tag_valid[MUL_LATENCY-1]) begin
                r_m_data  <= s_mul_data;
                r_m_id    <= r_tag_id[MUL_LATENCY-1];
                r_m_valid <= w_res_onehot;
            end else begin
                r_m_valid <= '0;
            end
        end
    end

    assign m_mul_valid = r_mul_valid;
    assign m_mul_data0 = r_mul_data0;
    assign m_mul_data1 = r_mul_data1;
    assign m_data      = r_m_data;
    assign m_id        = r_m_id;
    assign m_valid     = r_m_valid;

endmodule

// File: tb/tb_elixirchip_es1_spu_mul_arbiter.sv
// Drives a BURST=1 and a BURST=2 arbiter with shared stimulus, each with its own multiplier model,
// and checks every cycle against a transaction-level model plus hand-computed directed cases.
module tb_elixirchip_es1_spu_mul_arbiter;

    localparam int NP  = 4;
    localparam int LAT = 3;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        cke     = 1'b1;
    logic [31:0] s_data0 = '0;
    logic [31:0] s_data1 = '0;
    logic [3:0]  s_valid = '0;

    logic [3:0]  ready     [2];
    logic [7:0]  mul_d0    [2];
    logic [7:0]  mul_d1    [2];
    logic        mul_valid [2];
    logic [15:0] mul_res   [2];
    logic [15:0] m_data    [2];
    logic [1:0]  m_id      [2];
    logic [3:0]  m_valid   [2];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [15:0] r_pipe [LAT];
        always @(posedge clk) begin
            if (cke) begin
                r_pipe[0] <= 16'(mul_d0[g]) * 16'(mul_d1[g]);
                for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end
        assign mul_res[g] = r_pipe[LAT-1];

        elixirchip_es1_spu_mul_arbiter #(
            .NUM_PORTS   (NP),
            .DATA0_BITS  (8),
            .DATA1_BITS  (8),
            .RESULT_BITS (16),
            .MUL_LATENCY (LAT),
            .BURST       (g + 1)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .cke         (cke),
            .s_data0     (s_data0),
            .s_data1     (s_data1),
            .s_valid     (s_valid),
            .s_ready     (ready[g]),
            .m_mul_data0 (mul_d0[g]),
            .m_mul_data1 (mul_d1[g]),
            .m_mul_valid (mul_valid[g]),
            .s_mul_data  (mul_res[g]),
            .m_data      (m_data[g]),
            .m_id        (m_id[g]),
            .m_valid     (m_valid[g])
        );
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    int burst_of [2] = '{1, 2};
    int mptr     [2] = '{NP - 1, NP - 1};
    bit mhave    [2] = '{0, 0};
    int mcnt     [2] = '{0, 0};
    int mgrant   [2] = '{-1, -1};
    bit exp_mulv [2] = '{0, 0};
    int exp_a    [2] = '{0, 0};
    int exp_b    [2] = '{0, 0};
    int exp_mv   [2] = '{0, 0};
    int exp_md   [2] = '{0, 0};
    int exp_mid  [2] = '{0, 0};
    bit pend_v   [2][16];
    int pend_id  [2][16];
    int pend_d   [2][16];
    int n_edges = 0;

    function automatic int model_grant(input logic [3:0] v, input int ptr, input bit have,
                                       input int cnt, input int burst);
        if (have && v[ptr] == 1'b1 && cnt < burst - 1) return ptr;
        for (int k = 1; k <= NP; k++) begin
            if (v[(ptr + k) % NP] == 1'b1) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    // A result issued at enabled edge k appears after enabled edge k+LAT+1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_edges = 0;
            for (int g = 0; g < 2; g++) begin
                mptr[g] = NP - 1; mhave[g] = 0; mcnt[g] = 0;
                exp_mulv[g] = 0; exp_a[g] = 0; exp_b[g] = 0;
                exp_mv[g] = 0; exp_md[g] = 0; exp_mid[g] = 0;
                for (int s = 0; s < 16; s++) pend_v[g][s] = 0;
            end
        end else if (cke) begin
            n_edges++;
            for (int g = 0; g < 2; g++) begin
                int slot, w;
                slot = n_edges % 16;
                if (pend_v[g][slot]) begin
                    exp_mv[g]  = 1 << pend_id[g][slot];
                    exp_md[g]  = pend_d[g][slot];
                    exp_mid[g] = pend_id[g][slot];
                    pend_v[g][slot] = 0;
                end else begin
                    exp_mv[g] = 0;
                end
                w = mgrant[g];
                exp_mulv[g] = (w >= 0);
                if (w >= 0) begin
                    exp_a[g] = int'((s_data0 >> (8 * w)) & 32'hFF);
                    exp_b[g] = int'((s_data1 >> (8 * w)) & 32'hFF);
                    slot = (n_edges + LAT + 1) % 16;
                    pend_v[g][slot]  = 1;
                    pend_id[g][slot] = w;
                    pend_d[g][slot]  = (exp_a[g] * exp_b[g]) & 16'hFFFF;
                    mcnt[g]  = (mhave[g] && w == mptr[g]) ? mcnt[g] + 1 : 0;
                    mptr[g]  = w;
                    mhave[g] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            logic [3:0] exp_rdy;
            mgrant[g] = (reset_n && cke) ?
                        model_grant(s_valid, mptr[g], mhave[g], mcnt[g], burst_of[g]) : -1;
            exp_rdy = (mgrant[g] >= 0) ? 4'(1 << mgrant[g]) : 4'd0;
            chk("s_ready",         g, 32'(ready[g]),         32'(exp_rdy));
            chk("s_ready_onehot0", g, 32'($onehot0(ready[g])), 32'd1);
            chk("m_mul_valid",     g, 32'(mul_valid[g]),     32'(exp_mulv[g]));
            chk("m_mul_data0",     g, 32'(mul_d0[g]),        exp_a[g]);
            chk("m_mul_data1",     g, 32'(mul_d1[g]),        exp_b[g]);
            chk("m_valid",         g, 32'(m_valid[g]),       exp_mv[g]);
            chk("m_data",          g, 32'(m_data[g]),        exp_md[g]);
            chk("m_id",            g, 32'(m_id[g]),          exp_mid[g]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1, input logic ck);
        @(negedge clk);
        s_valid = v; s_data0 = d0; s_data1 = d1; cke = ck;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; s_valid = '0; cke = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Single request from port 0: 3*5.
        do_reset();
        drive(4'b0001, 32'h3, 32'h5, 1'b1); #2;
        chk("t1_ready", 0, 32'(ready[0]), 32'h1);
        drive(4'b0000, 32'h3, 32'h5, 1'b1); #2;
        chk("t1_mulv", 0, 32'(mul_valid[0]), 32'd1);
        chk("t1_op0",  0, 32'(mul_d0[0]), 32'd3);
        chk("t1_op1",  0, 32'(mul_d1[0]), 32'd5);
        repeat (3) drive(4'b0000, 32'h0, 32'h0, 1'b1);
        drive(4'b0000, 32'h0, 32'h0, 1'b1); #2;
        chk("t1_mvalid", 0, 32'(m_valid[0]), 32'h1);
        chk("t1_mdata",  0, 32'(m_data[0]),  32'd15);
        chk("t1_mid",    0, 32'(m_id[0]),    32'd0);

        // All ports requesting, BURST=1: strict rotation, results 10,20,30,40.
        do_reset();
        for (int k = 0; k < 13; k++) begin
            drive((k < 8) ? 4'hF : 4'h0, 32'h04030201, 32'h0A0A0A0A, 1'b1); #2;
            if (k < 8) chk("t2_grant", 0, 32'(ready[0]), 32'(1 << (k % 4)));
            if (k >= 5) begin
                chk("t2_mvalid", 0, 32'(m_valid[0]), 32'(1 << ((k - 5) % 4)));
                chk("t2_mdata",  0, 32'(m_data[0]),  32'(((k - 5) % 4 + 1) * 10));
                chk("t2_mid",    0, 32'(m_id[0]),    32'((k - 5) % 4));
            end
        end

        // BURST=2 with ports 1 and 2: pairs 1,1,2,2,1,1 with no issue gaps.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(4'b0110, 32'h00030200, 32'h000A0A00, 1'b1); #2;
            chk("t3_grant", 1, 32'(ready[1]), (k % 4 < 2) ? 32'h2 : 32'h4);
            if (k > 0) chk("t3_mulv", 1, 32'(mul_valid[1]), 32'd1);
        end
        repeat (8) drive(4'b0000, 32'h0, 32'h0, 1'b1);

        // Clock enable low for three cycles while 7*9 is in flight.
        do_reset();
        drive(4'b0001, 32'h7, 32'h9, 1'b1);
        drive(4'b0000, 32'h7, 32'h9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(4'hF, 32'h01010101, 32'h01010101, 1'b0); #2;
            chk("t4_ready_frozen", 0, 32'(ready[0]), 32'h0);
            chk("t4_ready_frozen", 1, 32'(ready[1]), 32'h0);
        end
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        drive(4'b0000, 32'h0, 32'h0, 1'b1); #2;
        chk("t4_not_early", 0, 32'(m_valid[0]), 32'h0);
        drive(4'b0000, 32'h0, 32'h0, 1'b1); #2;
        chk("t4_mvalid", 0, 32'(m_valid[0]), 32'h1);
        chk("t4_mdata",  0, 32'(m_data[0]),  32'd63);
        chk("t4_mid",    0, 32'(m_id[0]),    32'd0);

        // Reset with two operations in flight, then 255*255 from port 3.
        do_reset();
        drive(4'b0011, 32'h00000604, 32'h00000505, 1'b1);
        drive(4'b0011, 32'h00000604, 32'h00000505, 1'b1);
        @(negedge clk); reset_n = 1'b0; s_valid = '0;
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(4'b0000, 32'h0, 32'h0, 1'b1); #2;
            chk("t5_no_pulse", 0, 32'(m_valid[0]), 32'h0);
            chk("t5_no_pulse", 1, 32'(m_valid[1]), 32'h0);
        end
        drive(4'b1000, 32'hFF000000, 32'hFF000000, 1'b1); #2;
        chk("t5_ready", 0, 32'(ready[0]), 32'h8);
        repeat (4) drive(4'b0000, 32'h0, 32'h0, 1'b1);
        drive(4'b0000, 32'h0, 32'h0, 1'b1); #2;
        chk("t5_mvalid", 0, 32'(m_valid[0]), 32'h8);
        chk("t5_mdata",  0, 32'(m_data[0]),  32'd65025);
        chk("t5_mid",    0, 32'(m_id[0]),    32'd3);

        // Port 2 drops while port 0 waits with the pointer at 2.
        do_reset();
        drive(4'b0101, 32'h00020001, 32'h00020001, 1'b1); #2;
        chk("t6_first", 0, 32'(ready[0]), 32'h1);
        drive(4'b0101, 32'h00020001, 32'h00020001, 1'b1); #2;
        chk("t6_second", 0, 32'(ready[0]), 32'h4);
        drive(4'b0001, 32'h00020001, 32'h00020001, 1'b1); #2;
        chk("t6_rotate", 0, 32'(ready[0]), 32'h1);

        // Random traffic; a port keeps its request and operands until dut0 accepts it.
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            int prev;
            @(negedge clk);
            prev = mgrant[0];
            for (int i = 0; i < NP; i++) begin
                if (!s_valid[i] || prev == i) begin
                    s_valid[i] = ($urandom_range(0, 2) != 0);
                    s_data0[i*8 +: 8] = 8'($urandom);
                    s_data1[i*8 +: 8] = 8'($urandom);
                end
            end
            cke     = ($urandom_range(0, 9) != 0);
            reset_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1; cke = 1'b1; s_valid = '0;
        repeat (10) drive(4'b0000, 32'h0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
